// File: rtl/throw_pkg.sv
// Shared types and constants for the throw game round sequencer
// and the projectile controllers it drives.
package throw_pkg;

    typedef enum logic {
        DOG = 1'b0,
        CAT = 1'b1
    } player_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHARGE,
        ST_FLIGHT,
        ST_RESULT,
        ST_OVER
    } turn_state_t;

    // 65 MHz pixel clock -> 1 ms tick
    localparam int CLK_PER_MS = 65000;

    function automatic player_t other(input player_t p);
        return (p == DOG) ? CAT : DOG;
    endfunction

endpackage

// File: rtl/throw_turn_ctl_if.sv
// Bundle between input logic / projectile controllers / HUD and the
// turn sequencer. master = stimulus side, slave = throw_turn_ctl.
interface throw_turn_ctl_if;
    import throw_pkg::*;

    logic       btn_throw;
    logic       new_game;
    logic       land;
    logic       hit_cat;
    logic       hit_dog;
    logic [9:0] throw_force;
    logic       enable_dog;
    logic       enable_cat;
    player_t    turn;
    logic [6:0] hp_dog;
    logic [6:0] hp_cat;
    logic       game_over;
    player_t    winner;

    modport master (
        output btn_throw, new_game, land, hit_cat, hit_dog,
        input  throw_force, enable_dog, enable_cat, turn,
        input  hp_dog, hp_cat, game_over, winner
    );

    modport slave (
        input  btn_throw, new_game, land, hit_cat, hit_dog,
        output throw_force, enable_dog, enable_cat, turn,
        output hp_dog, hp_cat, game_over, winner
    );

endinterface

// File: rtl/ms_tick_gen.sv
// Free-running 1 ms tick divider: one-cycle pulse every CLK_PER_MS clocks.
// Ports: clk, rst (async, active high), tick (1-cycle pulse).
module ms_tick_gen #(
    parameter int CLK_PER_MS = throw_pkg::CLK_PER_MS
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_PER_MS - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick  = (cnt_q == LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/throw_turn_ctl.sv
// Round sequencer: alternates turns, charges throw force, enables the active
// projectile, scores hits into HP, declares winner. Ports: clk, rst, bus (slave).
module throw_turn_ctl
    import throw_pkg::*;
#(
    parameter int CLK_PER_MS      = throw_pkg::CLK_PER_MS,
    parameter int FORCE_MAX       = 1000,
    parameter int FORCE_STEP      = 2,
    parameter int HP_INIT         = 100,
    parameter int DAMAGE          = 20,
    parameter int LAND_TIMEOUT_MS = 6000,
    parameter int RESULT_HOLD_MS  = 1000
) (
    input  logic               clk,
    input  logic               rst,
    throw_turn_ctl_if.slave    bus
);

    localparam int MS_MAX = (LAND_TIMEOUT_MS > RESULT_HOLD_MS) ?
                            LAND_TIMEOUT_MS : RESULT_HOLD_MS;
    localparam int MS_W = $clog2(MS_MAX + 1);
    localparam logic [MS_W-1:0] T_LAND = MS_W'(LAND_TIMEOUT_MS);
    localparam logic [MS_W-1:0] T_HOLD = MS_W'(RESULT_HOLD_MS);
    localparam logic [6:0]      HP0    = 7'(HP_INIT);

    turn_state_t     state_q, state_d;
    player_t         turn_q, turn_d;
    player_t         win_q, win_d;
    logic [9:0]      force_q, force_d;
    logic [6:0]      hpd_q, hpd_d;
    logic [6:0]      hpc_q, hpc_d;
    logic [MS_W-1:0] ms_q, ms_d;
    logic            go_q, go_d;
    logic            en_dog_q, en_dog_d;
    logic            en_cat_q, en_cat_d;
    logic            btn_q;

    logic            tick;
    logic            btn_rise;
    logic            target_hit;
    logic            flying;
    logic [10:0]     f_sum;
    logic [9:0]      f_sat;

    ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // 8-bit signed subtract so an underflow shows up as negative, then clamp
    function automatic logic [6:0] dmg(input logic [6:0] hp);
        logic signed [7:0] d;
        d = $signed({1'b0, hp}) - $signed(8'(DAMAGE));
        return (d < 0) ? 7'd0 : d[6:0];
    endfunction

    assign btn_rise   = bus.btn_throw & ~btn_q;
    assign target_hit = (turn_q == DOG) ? bus.hit_cat : bus.hit_dog;
    assign f_sum      = {1'b0, force_q} + 11'(FORCE_STEP);
    assign f_sat      = (f_sum > 11'(FORCE_MAX)) ? 10'(FORCE_MAX) : f_sum[9:0];

    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        win_d   = win_q;
        force_d = force_q;
        hpd_d   = hpd_q;
        hpc_d   = hpc_q;
        go_d    = go_q;

        unique case (state_q)
            ST_IDLE: begin
                force_d = '0;
                if (btn_rise) state_d = ST_CHARGE;
            end
            ST_CHARGE: begin
                // release wins over a coincident tick
                if (!bus.btn_throw) state_d = ST_FLIGHT;
                else if (tick)      force_d = f_sat;
            end
            ST_FLIGHT: begin
                if (target_hit) begin
                    if (turn_q == DOG) hpc_d = dmg(hpc_q);
                    else               hpd_d = dmg(hpd_q);
                    state_d = ST_RESULT;
                end else if (bus.land || ms_q == T_LAND) begin
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (ms_q == T_HOLD) begin
                    force_d = '0;
                    if (hpd_q == '0 || hpc_q == '0) begin
                        state_d = ST_OVER;
                        go_d    = 1'b1;
                        win_d   = (hpc_q == '0) ? DOG : CAT;
                    end else begin
                        state_d = ST_IDLE;
                        turn_d  = other(turn_q);
                    end
                end
            end
            ST_OVER: begin
                if (bus.new_game) begin
                    state_d = ST_IDLE;
                    hpd_d   = HP0;
                    hpc_d   = HP0;
                    turn_d  = DOG;
                    win_d   = DOG;
                    go_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // one ms counter serves both flight timeout and result hold
        if (state_d != state_q || !(state_q inside {ST_FLIGHT, ST_RESULT}))
            ms_d = '0;
        else if (tick)
            ms_d = ms_q + 1'b1;
        else
            ms_d = ms_q;

        // enable drops on the same edge that leaves ST_RESULT
        flying   = (state_q == ST_FLIGHT) ||
                   (state_q == ST_RESULT && state_d == ST_RESULT);
        en_dog_d = flying && (turn_q == DOG);
        en_cat_d = flying && (turn_q == CAT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            turn_q   <= DOG;
            win_q    <= DOG;
            force_q  <= '0;
            hpd_q    <= HP0;
            hpc_q    <= HP0;
            ms_q     <= '0;
            go_q     <= 1'b0;
            en_dog_q <= 1'b0;
            en_cat_q <= 1'b0;
            btn_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            turn_q   <= turn_d;
            win_q    <= win_d;
            force_q  <= force_d;
            hpd_q    <= hpd_d;
            hpc_q    <= hpc_d;
            ms_q     <= ms_d;
            go_q     <= go_d;
            en_dog_q <= en_dog_d;
            en_cat_q <= en_cat_d;
            btn_q    <= bus.btn_throw;
        end
    end

    assign bus.throw_force = force_q;
    assign bus.enable_dog  = en_dog_q;
    assign bus.enable_cat  = en_cat_q;
    assign bus.turn        = turn_q;
    assign bus.hp_dog      = hpd_q;
    assign bus.hp_cat      = hpc_q;
    assign bus.game_over   = go_q;
    assign bus.winner      = win_q;

endmodule
